// File: rtl/cim_temp_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cim_temp_mem_arbiter_pkg
//   Shared types and constants for the CiM temporary-result memory path:
//   - MEM_ACCESS_SRC_T : requester identities; enum value = request-vector bit
//   - N_STORAGE        : SRAM word width
//   - TEMP_RES_STORAGE_SIZE_CIM : SRAM depth in words
//   - CIM_TEMP_MEM_RD_LAT       : SRAM read latency in cycles
//   - onehot_lowest()  : isolates the lowest set bit of a source vector
// -----------------------------------------------------------------------------
package cim_temp_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    BUS_FSM                  = 3'd0,
    LOGIC_FSM                = 3'd1,
    DATA_FILL_FSM            = 3'd2,
    DENSE_BROADCAST_SAVE_FSM = 3'd3,
    MAC                      = 3'd4,
    LAYERNORM                = 3'd5,
    SOFTMAX                  = 3'd6
  } MEM_ACCESS_SRC_T;

  localparam int MEM_ACCESS_SRC_NUM        = 7;
  localparam int N_STORAGE                 = 16;
  localparam int TEMP_RES_STORAGE_SIZE_CIM = 1024;
  localparam int CIM_TEMP_MEM_RD_LAT       = 2;

  typedef logic [MEM_ACCESS_SRC_NUM-1:0] src_vec_t;

  // Two's-complement trick: vec & -vec keeps only the lowest set bit, which
  // is the highest-priority requester (BUS_FSM = bit 0).
  function automatic src_vec_t onehot_lowest(input src_vec_t vec);
    return vec & (~vec + src_vec_t'(1));
  endfunction

endpackage

// File: rtl/cim_temp_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// cim_temp_mem_arbiter_if
//   Per-CiM memory-access request bundle.
//   - read_req_src  : one-hot read request per source
//   - write_req_src : one-hot write request per source
//   - addr_table    : per-source SRAM address
//   - write_data    : per-source write data
//   master = request producers, slave = the arbiter.
// -----------------------------------------------------------------------------
interface cim_temp_mem_arbiter_if
  import cim_temp_mem_arbiter_pkg::*;
#(
  parameter int NUM_SRC = MEM_ACCESS_SRC_NUM,
  parameter int ADDR_W  = $clog2(TEMP_RES_STORAGE_SIZE_CIM),
  parameter int DATA_W  = N_STORAGE
) ();

  logic [NUM_SRC-1:0]             read_req_src;
  logic [NUM_SRC-1:0]             write_req_src;
  logic [NUM_SRC-1:0][ADDR_W-1:0] addr_table;
  logic [NUM_SRC-1:0][DATA_W-1:0] write_data;

  modport master (
    output read_req_src,
    output write_req_src,
    output addr_table,
    output write_data
  );

  modport slave (
    input read_req_src,
    input write_req_src,
    input addr_table,
    input write_data
  );

endinterface

// File: rtl/cim_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// cim_rd_tag_pipe
//   RD_LAT-deep shift register of one-hot source tags that tracks reads in
//   flight through the SRAM. An all-zero tag marks an idle slot.
//   - clk, rst_n : clock, asynchronous active-low clear
//   - push_tag   : tag of the read issued this cycle (0 if none)
//   - pop_tag    : tag whose SRAM data is on sram_rdata this cycle
// -----------------------------------------------------------------------------
module cim_rd_tag_pipe #(
  parameter int NUM_SRC = 7,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] push_tag,
  output logic [NUM_SRC-1:0] pop_tag
);

  logic [RD_LAT-1:0][NUM_SRC-1:0] stage;

  // NOTE: every stage is a flop and is cleared, so reads in flight at reset
  // can never surface afterwards; this is not a RAM, so reset costs nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign pop_tag = stage[RD_LAT-1];

endmodule

// File: rtl/cim_temp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cim_temp_mem_arbiter
//   Arbitrates the per-CiM request bundle onto the single-port temporary
//   result SRAM: writes beat reads, lowest source index wins within a class,
//   losers are dropped. Reads are tagged through the SRAM latency and return
//   registered data with the originating source.
//   Ports:
//   - clk, rst_n            : clock, asynchronous active-low reset
//   - req (slave)           : read/write request vectors, address/data tables
//   - sram_en/wen/addr/wdata: SRAM command (combinational, 0 in reset)
//   - sram_rdata            : SRAM read data, RD_LAT cycles after the access
//   - grant                 : one-hot winner this cycle (combinational)
//   - rd_data/valid/src     : registered read return, one-cycle valid pulse
//   - conflict_err/cnt      : sticky multi-request flag, saturating count
// -----------------------------------------------------------------------------
module cim_temp_mem_arbiter
  import cim_temp_mem_arbiter_pkg::*;
#(
  // NUM_SRC must stay equal to MEM_ACCESS_SRC_NUM: the priority helper is
  // sized by the package source count.
  parameter int NUM_SRC = MEM_ACCESS_SRC_NUM,
  parameter int ADDR_W  = $clog2(TEMP_RES_STORAGE_SIZE_CIM),
  parameter int DATA_W  = N_STORAGE,
  parameter int RD_LAT  = CIM_TEMP_MEM_RD_LAT,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cim_temp_mem_arbiter_if.slave  req,
  output logic                   sram_en,
  output logic                   sram_wen,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  input  logic [DATA_W-1:0]      sram_rdata,
  output logic [NUM_SRC-1:0]     grant,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [NUM_SRC-1:0]     rd_src,
  output logic                   conflict_err,
  output logic [CNT_W-1:0]       conflict_cnt
);

  src_vec_t wr_win;
  src_vec_t rd_win;
  src_vec_t any_req;
  src_vec_t rd_push;
  src_vec_t tag_out;
  logic     conflict;

  // ---------------------------------------------------------------------------
  // Arbitration and SRAM command
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_win     = onehot_lowest(req.write_req_src);
    rd_win     = onehot_lowest(req.read_req_src);
    grant      = '0;
    rd_push    = '0;
    sram_en    = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    // Outputs are held at zero while reset is asserted so the SRAM sees no
    // spurious access during power-up or a mid-operation reset.
    if (rst_n) begin
      if (|req.write_req_src) begin
        grant    = wr_win;
        sram_en  = 1'b1;
        sram_wen = 1'b1;
      end else if (|req.read_req_src) begin
        grant   = rd_win;
        sram_en = 1'b1;
        rd_push = rd_win;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant[i]) begin
          sram_addr = req.addr_table[i];
          if (sram_wen) sram_wdata = req.write_data[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Conflict detection: more than one requesting source (x & (x-1) clears the
  // lowest bit, non-zero means a second bit was set), or one source asking
  // for both read and write.
  // ---------------------------------------------------------------------------
  always_comb begin
    any_req  = req.read_req_src | req.write_req_src;
    conflict = ((any_req & (any_req - src_vec_t'(1))) != '0) ||
               ((req.read_req_src & req.write_req_src) != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_err <= 1'b0;
      conflict_cnt <= '0;
    end else if (conflict) begin
      conflict_err <= 1'b1;
      if (conflict_cnt != {CNT_W{1'b1}}) conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag tracking and data return
  // ---------------------------------------------------------------------------
  cim_rd_tag_pipe #(
    .NUM_SRC (NUM_SRC),
    .RD_LAT  (RD_LAT)
  ) u_rd_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_tag (rd_push),
    .pop_tag  (tag_out)
  );

  // The emerging tag lines up with sram_rdata; an empty tag leaves rd_data
  // untouched so stale SRAM output never reaches the requesters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_src   <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= |tag_out;
      rd_src   <= tag_out;
      if (|tag_out) rd_data <= sram_rdata;
    end
  end

endmodule
